// File: rtl/axis_rx_checker.sv
// Receive-side checker for the 40G AXIS test-frame generator: restores logical byte
// order, checks each frame against the fixed format, reports pass/fail and counts.
module axis_rx_checker #(
  parameter int          P_FRAME_LEN = 10,
  parameter logic [47:0] P_SRC_MAC   = 48'h01_02_03_04_05_06,
  parameter logic [47:0] P_DST_MAC   = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [15:0] P_TYPE      = 16'h0800
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_stat_rx_status,
  input  logic         s_axis_rx_tvalid,
  input  logic [255:0] s_axis_rx_tdata,
  input  logic         s_axis_rx_tlast,
  input  logic [31:0]  s_axis_rx_tkeep,
  input  logic         s_axis_rx_tuser,
  output logic         o_link_ok,
  output logic         o_frame_ok,
  output logic         o_frame_err,
  output logic [3:0]   o_err_type,
  output logic [31:0]  o_good_cnt,
  output logic [31:0]  o_bad_cnt
);

  typedef enum logic [1:0] {S_WAIT_LINK, S_IDLE, S_DATA, S_DROP} state_t;

  localparam logic [15:0]  LAST_BEAT = 16'(P_FRAME_LEN - 1);
  localparam logic [255:0] HDR_BEAT  = {P_DST_MAC, P_SRC_MAC, P_TYPE, {18{8'haa}}};

  state_t        state_q, state_d;
  logic [15:0]   beat_cnt_q, beat_cnt_d;
  logic [3:0]    flags_q, flags_d;
  logic          link_ok_q, frame_ok_q, frame_err_q;
  logic [3:0]    err_type_q;
  logic [31:0]   good_cnt_q, bad_cnt_q;

  logic [255:0]  ld;
  logic [31:0]   lk;
  logic [15:0]   idx;
  logic [15:0]   idx_m1;
  logic [255:0]  exp_data;
  logic [3:0]    beat_flags, flags_all, report_flags;
  logic          report;

  // MAC order puts byte 0 in the low lane; the frame format is written MSB-first.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_swap
      assign ld[255-8*gi -: 8] = s_axis_rx_tdata[8*gi +: 8];
      assign lk[31-gi]         = s_axis_rx_tkeep[gi];
    end
  endgenerate

  always_comb begin
    idx        = (state_q == S_DATA) ? beat_cnt_q : 16'd0;
    idx_m1     = idx - 16'd1;
    exp_data   = (idx == 16'd0) ? HDR_BEAT :
                 (idx == 16'd1) ? {16{16'haabb}} : {16{idx_m1}};
    beat_flags    = '0;
    beat_flags[0] = (idx == 16'd0) && (ld != exp_data);
    beat_flags[1] = (idx != 16'd0) && (ld != exp_data);
    beat_flags[2] = s_axis_rx_tlast ? (idx != LAST_BEAT) : (idx == LAST_BEAT);
    beat_flags[3] = (lk != 32'hffff_ffff) || s_axis_rx_tuser;
    flags_all     = flags_q | beat_flags;
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    flags_d      = flags_q;
    report       = 1'b0;
    report_flags = flags_all;
    if (!link_ok_q) begin
      state_d    = S_WAIT_LINK;
      beat_cnt_d = '0;
      flags_d    = '0;
    end else begin
      case (state_q)
        S_WAIT_LINK: begin
          if (!s_axis_rx_tvalid || s_axis_rx_tlast) state_d = S_IDLE;
        end
        S_IDLE, S_DATA: begin
          if (s_axis_rx_tvalid) begin
            if (s_axis_rx_tlast) begin
              report     = 1'b1;
              flags_d    = '0;
              beat_cnt_d = '0;
              state_d    = S_IDLE;
            end else if (idx == LAST_BEAT) begin
              flags_d    = flags_all;
              beat_cnt_d = '0;
              state_d    = S_DROP;
            end else begin
              flags_d    = flags_all;
              beat_cnt_d = idx + 16'd1;
              state_d    = S_DATA;
            end
          end
        end
        S_DROP: begin
          // Overlong frame: remaining beats are not inspected, only its end matters.
          if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
            report       = 1'b1;
            report_flags = flags_q;
            flags_d      = '0;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_WAIT_LINK;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_WAIT_LINK;
      beat_cnt_q  <= '0;
      flags_q     <= '0;
      link_ok_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_type_q  <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      flags_q     <= flags_d;
      link_ok_q   <= i_stat_rx_status;
      frame_ok_q  <= report && (report_flags == 4'd0);
      frame_err_q <= report && (report_flags != 4'd0);
      if (report && (report_flags != 4'd0)) begin
        err_type_q <= report_flags;
        if (bad_cnt_q != 32'hffff_ffff) bad_cnt_q <= bad_cnt_q + 32'd1;
      end
      if (report && (report_flags == 4'd0) && (good_cnt_q != 32'hffff_ffff))
        good_cnt_q <= good_cnt_q + 32'd1;
    end
  end

  assign o_link_ok   = link_ok_q;
  assign o_frame_ok  = frame_ok_q;
  assign o_frame_err = frame_err_q;
  assign o_err_type  = err_type_q;
  assign o_good_cnt  = good_cnt_q;
  assign o_bad_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_axis_rx_checker.sv
// Scoreboard bench for axis_rx_checker: directed frames push expected reports,
// a negedge monitor pops and checks pulses, timing, error type and counters.
module tb_axis_rx_checker;

  localparam logic [47:0] SRC  = 48'h01_02_03_04_05_06;
  localparam logic [47:0] DST  = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [15:0] TYP  = 16'h0800;

  logic         clk = 1'b0;
  logic         rst;
  logic         status;
  logic         tvalid;
  logic [255:0] tdata;
  logic         tlast;
  logic [31:0]  tkeep;
  logic         tuser;
  logic         link_ok, frame_ok, frame_err;
  logic [3:0]   err_type;
  logic [31:0]  good_cnt, bad_cnt;

  always #5 clk = ~clk;

  axis_rx_checker dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stat_rx_status (status),
    .s_axis_rx_tvalid (tvalid),
    .s_axis_rx_tdata  (tdata),
    .s_axis_rx_tlast  (tlast),
    .s_axis_rx_tkeep  (tkeep),
    .s_axis_rx_tuser  (tuser),
    .o_link_ok        (link_ok),
    .o_frame_ok       (frame_ok),
    .o_frame_err      (frame_err),
    .o_err_type       (err_type),
    .o_good_cnt       (good_cnt),
    .o_bad_cnt        (bad_cnt)
  );

  typedef struct {
    logic       ok;
    logic [3:0] err;
    int         at;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] good_exp = '0;
  logic [31:0] bad_exp  = '0;
  logic [3:0]  err_exp  = '0;
  logic        corrupt_src = 1'b0;
  logic        bad_beat4   = 1'b0;
  logic        keep_beat7  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sb.size() > 0 && cyc > sb[0].at) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL missing_pulse: got none want report at cycle %0d", e.at);
      end
      if (frame_ok || frame_err) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got ok=%0b err=%0b want none (cycle %0d)",
                   frame_ok, frame_err, cyc);
        end else begin
          e = sb.pop_front();
          if (e.ok) good_exp = (good_exp == 32'hffff_ffff) ? good_exp : good_exp + 32'd1;
          else begin
            bad_exp = (bad_exp == 32'hffff_ffff) ? bad_exp : bad_exp + 32'd1;
            err_exp = e.err;
          end
          chk("pulse_ok",    32'(frame_ok),  32'(e.ok));
          chk("pulse_err",   32'(frame_err), 32'(!e.ok));
          chk("pulse_cycle", 32'(cyc),       32'(e.at));
          chk("err_type",    32'(err_type),  32'(err_exp));
          chk("good_cnt",    good_cnt,       good_exp);
          chk("bad_cnt",     bad_cnt,        bad_exp);
          $display("frame report at cycle %0d: ok=%0b err_type=%b good=%0d bad=%0d",
                   cyc, frame_ok, err_type, good_cnt, bad_cnt);
        end
      end
    end
  end

  function automatic logic [255:0] gen_beat(input int n);
    logic [15:0] v;
    if (n == 0) return {DST, SRC, TYP, {18{8'haa}}};
    if (n == 1) return {16{16'haabb}};
    v = 16'(n - 1);
    return {16{v}};
  endfunction

  task automatic drive_beat(input logic [255:0] l, input logic [31:0] lk, input logic last);
    for (int k = 0; k < 32; k++) begin
      tdata[8*k +: 8] = l[255-8*k -: 8];
      tkeep[k]        = lk[31-k];
    end
    tvalid = 1'b1;
    tlast  = last;
    tuser  = 1'b0;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends up to nb beats, tlast on beat tl_at; expected report supplied by caller.
  task automatic send_frame(input int nb, input int tl_at, input logic ok, input logic [3:0] err);
    logic [255:0] d;
    logic [31:0]  lk;
    exp_t         e;
    for (int b = 0; b < nb; b++) begin
      d  = gen_beat(b);
      lk = 32'hffff_ffff;
      if (corrupt_src && b == 0) d[167:160] = 8'h07;
      if (bad_beat4 && b == 4)   d = {16{16'h0004}};
      if (keep_beat7 && b == 7)  lk = 32'h7fff_ffff;
      if (b == tl_at) begin
        e.ok = ok; e.err = err; e.at = cyc + 1;
        sb.push_back(e);
      end
      drive_beat(d, lk, b == tl_at);
      if (b == tl_at) break;
    end
  endtask

  initial begin
    rst = 1'b1; status = 1'b0; tvalid = 1'b0; tdata = '0;
    tlast = 1'b0; tkeep = '0; tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_link_ok",   32'(link_ok),   32'd0);
    chk("rst_frame_ok",  32'(frame_ok),  32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_err_type",  32'(err_type),  32'd0);
    chk("rst_good_cnt",  good_cnt,       32'd0);
    chk("rst_bad_cnt",   bad_cnt,        32'd0);

    @(posedge clk); #1;
    status = 1'b1;
    idle(3);
    chk("link_up", 32'(link_ok), 32'd1);

    // Three back-to-back clean frames.
    send_frame(10, 9, 1'b1, 4'b0000);
    send_frame(10, 9, 1'b1, 4'b0000);
    send_frame(10, 9, 1'b1, 4'b0000);
    idle(2);
    chk("good_after_3", good_cnt, 32'd3);
    chk("bad_after_3",  bad_cnt,  32'd0);

    // Wrong source MAC, then a clean frame.
    corrupt_src = 1'b1;
    send_frame(10, 9, 1'b0, 4'b0001);
    corrupt_src = 1'b0;
    send_frame(10, 9, 1'b1, 4'b0000);

    // Short frame, then overlong frame (12 beats).
    send_frame(10, 5, 1'b0, 4'b0100);
    send_frame(12, 11, 1'b0, 4'b0100);

    // Payload error on beat 4 plus keep error on beat 7, then a clean frame.
    bad_beat4 = 1'b1; keep_beat7 = 1'b1;
    send_frame(10, 9, 1'b0, 4'b1010);
    bad_beat4 = 1'b0; keep_beat7 = 1'b0;
    send_frame(10, 9, 1'b1, 4'b0000);
    idle(2);

    // Link drops at beat 4 and returns at beat 6: frame aborted silently.
    for (int b = 0; b < 10; b++) begin
      if (b == 4) status = 1'b0;
      if (b == 6) status = 1'b1;
      drive_beat(gen_beat(b), 32'hffff_ffff, b == 9);
    end
    idle(3);
    chk("linkdrop_good",  good_cnt,       32'd5);
    chk("linkdrop_bad",   bad_cnt,        32'd4);
    chk("linkdrop_err",   32'(err_type),  32'hA);
    send_frame(10, 9, 1'b1, 4'b0000);
    idle(2);

    // Saturation of the good counter.
    force dut.good_cnt_q = 32'hffff_fffe;
    idle(1);
    release dut.good_cnt_q;
    good_exp = 32'hffff_fffe;
    send_frame(10, 9, 1'b1, 4'b0000);
    send_frame(10, 9, 1'b1, 4'b0000);
    send_frame(10, 9, 1'b1, 4'b0000);
    idle(3);
    chk("sat_good",   good_cnt,        32'hffff_ffff);
    chk("sat_bad",    bad_cnt,         32'd4);
    chk("sb_drained", 32'(sb.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
